// File: rtl/entropy_dc_slice_scheduler.sv
// rtl/entropy_dc_slice_scheduler.sv - sequences one slice of DC coefficients through the DC entropy encoder
module entropy_dc_slice_scheduler #(
    parameter int MAX_BLOCKS = 32,
    parameter int ADDR_W     = 5,
    parameter int ENC_LAT    = 4,
    parameter int CLR_CYC    = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              slice_start,
    input  logic [5:0]        slice_num_blocks,
    output logic              slice_busy,
    output logic              slice_done,
    output logic              coef_rd_en,
    output logic [ADDR_W-1:0] coef_rd_addr,
    input  logic [19:0]       coef_rd_data,
    output logic              enc_rst_n,
    output logic [19:0]       enc_dc_coeff,
    input  logic [23:0]       enc_sum,
    input  logic [23:0]       enc_length,
    output logic              cw_valid,
    input  logic              cw_ready,
    output logic [23:0]       cw_bits,
    output logic [5:0]        cw_len,
    output logic              cw_last
);

    localparam int TAG_D = 2 + ENC_LAT;
    localparam int CNT_W = $clog2(MAX_BLOCKS + 1);
    localparam int CLR_W = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;
    localparam int FW    = 24 + 6 + 1;

    typedef enum logic [2:0] {IDLE, CLEAR, STREAM, FLUSH, DRAIN} state_t;

    state_t             state;
    logic [CLR_W-1:0]   clr_cnt;
    logic [ADDR_W-1:0]  last_addr;
    logic               rd_d1;
    logic [TAG_D-1:0]   tag_pipe;
    logic [TAG_D-1:0]   last_pipe;

    logic [FW-1:0]      fifo_mem [MAX_BLOCKS];
    logic [ADDR_W-1:0]  wr_ptr;
    logic [ADDR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [FW-1:0]      head;
    logic               push;
    logic               pop;
    logic               fifo_empty;
    logic [5:0]         n_clamped;
    logic               unused_len_hi;

    assign unused_len_hi = ^enc_length[23:6];

    always_comb begin
        n_clamped = slice_num_blocks;
        if (slice_num_blocks == 6'd0)
            n_clamped = 6'd1;
        else if (slice_num_blocks > 6'(MAX_BLOCKS))
            n_clamped = 6'(MAX_BLOCKS);
    end

    // Tags ride alongside each read so the encoder's output is captured exactly when it matches.
    assign push       = tag_pipe[TAG_D-1];
    assign fifo_empty = (count == '0);
    assign cw_valid   = !fifo_empty;
    assign pop        = cw_valid && cw_ready;
    assign head       = fifo_mem[rd_ptr];
    assign cw_bits    = cw_valid ? head[FW-1:7] : '0;
    assign cw_len     = cw_valid ? head[6:1]    : '0;
    assign cw_last    = cw_valid ? head[0]      : 1'b0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            clr_cnt      <= '0;
            last_addr    <= '0;
            rd_d1        <= 1'b0;
            tag_pipe     <= '0;
            last_pipe    <= '0;
            slice_busy   <= 1'b0;
            slice_done   <= 1'b0;
            coef_rd_en   <= 1'b0;
            coef_rd_addr <= '0;
            enc_rst_n    <= 1'b0;
            enc_dc_coeff <= '0;
        end else begin
            slice_done <= 1'b0;
            rd_d1      <= coef_rd_en;
            tag_pipe   <= {tag_pipe[TAG_D-2:0], coef_rd_en};
            last_pipe  <= {last_pipe[TAG_D-2:0], coef_rd_en && (coef_rd_addr == last_addr)};
            if (rd_d1)
                enc_dc_coeff <= coef_rd_data;
            case (state)
                IDLE: begin
                    enc_rst_n <= 1'b1;
                    if (slice_start && fifo_empty) begin
                        last_addr    <= ADDR_W'(n_clamped - 6'd1);
                        slice_busy   <= 1'b1;
                        clr_cnt      <= '0;
                        enc_rst_n    <= 1'b0;
                        enc_dc_coeff <= '0;
                        state        <= CLEAR;
                    end
                end
                CLEAR: begin
                    enc_dc_coeff <= '0;
                    if (clr_cnt == CLR_W'(CLR_CYC - 1)) begin
                        enc_rst_n    <= 1'b1;
                        coef_rd_en   <= 1'b1;
                        coef_rd_addr <= '0;
                        state        <= STREAM;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                STREAM: begin
                    if (coef_rd_addr == last_addr) begin
                        coef_rd_en <= 1'b0;
                        state      <= FLUSH;
                    end else begin
                        coef_rd_addr <= coef_rd_addr + 1'b1;
                    end
                end
                FLUSH: begin
                    if (tag_pipe[TAG_D-1] && last_pipe[TAG_D-1])
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (pop && cw_last) begin
                        slice_done <= 1'b1;
                        slice_busy <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= {enc_sum, enc_length[5:0], last_pipe[TAG_D-1]};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Starts wait for an empty FIFO, so a full FIFO receiving an unpaired push is a design error.
    assert property (@(posedge clk) disable iff (!reset_n)
        !(push && !pop && (count == CNT_W'(MAX_BLOCKS))));

endmodule

// File: tb/tb_entropy_dc_slice_scheduler.sv
// tb/tb_entropy_dc_slice_scheduler.sv - directed bench for entropy_dc_slice_scheduler
module tb_entropy_dc_slice_scheduler;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        slice_start = 1'b0;
    logic [5:0]  slice_num_blocks = 6'd0;
    logic        slice_busy, slice_done, coef_rd_en;
    logic [4:0]  coef_rd_addr;
    logic [19:0] coef_rd_data = 20'd0;
    logic        enc_rst_n;
    logic [19:0] enc_dc_coeff;
    logic [23:0] enc_sum, enc_length;
    logic        cw_valid;
    logic        cw_ready = 1'b0;
    logic [23:0] cw_bits;
    logic [5:0]  cw_len;
    logic        cw_last;

    entropy_dc_slice_scheduler dut (
        .clk(clk), .reset_n(reset_n),
        .slice_start(slice_start), .slice_num_blocks(slice_num_blocks),
        .slice_busy(slice_busy), .slice_done(slice_done),
        .coef_rd_en(coef_rd_en), .coef_rd_addr(coef_rd_addr), .coef_rd_data(coef_rd_data),
        .enc_rst_n(enc_rst_n), .enc_dc_coeff(enc_dc_coeff),
        .enc_sum(enc_sum), .enc_length(enc_length),
        .cw_valid(cw_valid), .cw_ready(cw_ready),
        .cw_bits(cw_bits), .cw_len(cw_len), .cw_last(cw_last)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference DC codeword: '1', sign, then k magnitude bits; zero difference is a 1-bit '0'.
    function automatic logic [29:0] enc_fn(input logic signed [20:0] d);
        logic [20:0] mag;
        logic        s;
        int          k;
        s   = d[20];
        mag = s ? 21'(-d) : 21'(d);
        k   = 0;
        for (int i = 0; i < 21; i++) if (mag[i]) k = i + 1;
        if (k == 0) return {24'd0, 6'd1};
        return {(24'({1'b1, s}) << k) | 24'(mag), 6'(k + 2)};
    endfunction

    logic [19:0] coef_mem [0:31];
    always @(posedge clk) if (coef_rd_en) coef_rd_data <= coef_mem[coef_rd_addr];

    logic [19:0] enc_prev = 20'd0;
    logic [29:0] enc_p [0:3];
    initial for (int i = 0; i < 4; i++) enc_p[i] = 30'd0;
    always @(posedge clk) begin
        if (!enc_rst_n) begin
            enc_prev <= 20'd0;
            for (int i = 0; i < 4; i++) enc_p[i] <= 30'd0;
        end else begin
            enc_p[0] <= enc_fn($signed({enc_dc_coeff[19], enc_dc_coeff}) - $signed({enc_prev[19], enc_prev}));
            enc_p[1] <= enc_p[0];
            enc_p[2] <= enc_p[1];
            enc_p[3] <= enc_p[2];
            enc_prev <= enc_dc_coeff;
        end
    end
    assign enc_sum    = enc_p[3][29:6];
    assign enc_length = {18'h2a5, enc_p[3][5:0]};

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [30:0] got_q[$];
    logic [30:0] exp_q[$];
    int rd_cnt, rd_first, rd_last, addr_err, done_cnt, done_cyc, first_valid_cyc, last_xfer_cyc, busy_err;

    task automatic mon_clear();
        got_q.delete();
        rd_cnt = 0; rd_first = 0; rd_last = -1; addr_err = 0;
        done_cnt = 0; done_cyc = -1; first_valid_cyc = -1; last_xfer_cyc = -100; busy_err = 0;
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (coef_rd_en) begin
                if (rd_cnt == 0) rd_first = cyc;
                rd_last = cyc;
                if (int'(coef_rd_addr) != rd_cnt) addr_err++;
                rd_cnt++;
            end
            if (cw_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (cw_valid && cw_ready) begin
                got_q.push_back({cw_bits, cw_len, cw_last});
                if (cw_last) last_xfer_cyc = cyc;
            end
            if (slice_done) begin
                done_cnt++;
                done_cyc = cyc;
                if (slice_busy) busy_err++;
            end
        end
    end

    // mode 0: ready high; mode 1: ready low until cycle 'hold'; mode 2: random ready.
    task automatic run_slice(input string name, input int n_req, input int mode,
                             input int hold, input int restart_off);
        int          n_eff, start_cyc;
        logic [19:0] prev;
        n_eff = (n_req == 0) ? 1 : ((n_req > 32) ? 32 : n_req);
        exp_q.delete();
        prev = 20'd0;
        for (int i = 0; i < n_eff; i++) begin
            logic [29:0] e;
            e = enc_fn($signed({coef_mem[i][19], coef_mem[i]}) - $signed({prev[19], prev}));
            exp_q.push_back({e, (i == n_eff - 1)});
            prev = coef_mem[i];
        end
        @(posedge clk); #1;
        mon_clear();
        start_cyc        = cyc;
        slice_start      = 1'b1;
        slice_num_blocks = 6'(n_req);
        cw_ready         = (mode == 0);
        @(posedge clk); #1;
        slice_start = 1'b0;
        check_eq({name, "_busy_on_start"}, slice_busy, 1);
        for (int k = 1; k <= 3000; k++) begin
            if (mode == 1 && k == hold) begin
                check_eq({name, "_hold_no_xfer"}, got_q.size(), 0);
                check_eq({name, "_hold_valid"}, cw_valid, 1);
            end
            if (mode == 0) cw_ready = 1'b1;
            else if (mode == 1) cw_ready = (k >= hold);
            else cw_ready = 1'($urandom_range(0, 1));
            if (restart_off != 0 && k == restart_off) begin
                slice_start      = 1'b1;
                slice_num_blocks = 6'd3;
            end else begin
                slice_start = 1'b0;
            end
            @(posedge clk); #1;
            if (restart_off != 0 && k == restart_off)
                check_eq({name, "_restart_busy"}, slice_busy, 1);
            if (done_cnt > 0) break;
        end
        slice_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq({name, "_done_count"}, done_cnt, 1);
        check_eq({name, "_done_after_last"}, done_cyc, last_xfer_cyc + 1);
        check_eq({name, "_busy_low_at_done"}, busy_err, 0);
        check_eq({name, "_busy_end"}, slice_busy, 0);
        check_eq({name, "_valid_end"}, cw_valid, 0);
        check_eq({name, "_rd_count"}, rd_cnt, n_eff);
        check_eq({name, "_rd_contig"}, rd_last - rd_first + 1, n_eff);
        check_eq({name, "_rd_addr_order"}, addr_err, 0);
        check_eq({name, "_first_latency_ge8"}, (first_valid_cyc - start_cyc) >= 8, 1);
        check_eq({name, "_cw_count"}, got_q.size(), n_eff);
        for (int i = 0; i < n_eff && i < got_q.size(); i++)
            check_eq($sformatf("%s_cw%0d", name, i), got_q[i], exp_q[i]);
    endtask

    initial begin
        mon_clear();
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", slice_busy, 0);
        check_eq("rst_done", slice_done, 0);
        check_eq("rst_rd_en", coef_rd_en, 0);
        check_eq("rst_rd_addr", coef_rd_addr, 0);
        check_eq("rst_enc_rst_n", enc_rst_n, 0);
        check_eq("rst_enc_coeff", enc_dc_coeff, 0);
        check_eq("rst_cw_valid", cw_valid, 0);
        check_eq("rst_cw_bits", cw_bits, 0);
        check_eq("rst_cw_len", cw_len, 0);
        check_eq("rst_cw_last", cw_last, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check_eq("idle_enc_rst_n", enc_rst_n, 1);

        for (int i = 0; i < 4; i++) coef_mem[i] = 20'd100;
        run_slice("n4", 4, 0, 0, 0);

        coef_mem[0] = 20'd0;
        run_slice("n1", 1, 0, 0, 0);

        for (int i = 0; i < 32; i++) coef_mem[i] = 20'(i * 37 - 500);
        run_slice("n32hold", 32, 1, 60, 0);

        for (int i = 0; i < 8; i++) coef_mem[i] = 20'($urandom);
        run_slice("n8rand", 8, 2, 0, 0);

        for (int i = 0; i < 8; i++) coef_mem[i] = 20'(-(i * i * 11) + 7);
        run_slice("n8restart", 8, 0, 0, 5);

        coef_mem[0] = 20'hfff00;
        run_slice("n0", 0, 0, 0, 0);

        for (int i = 0; i < 32; i++) coef_mem[i] = 20'(i[0] ? 300 : -300);
        run_slice("n40", 40, 0, 0, 0);

        for (int i = 0; i < 8; i++) coef_mem[i] = 20'(i * 1000);
        @(posedge clk); #1;
        cw_ready         = 1'b0;
        slice_start      = 1'b1;
        slice_num_blocks = 6'd8;
        @(posedge clk); #1;
        slice_start = 1'b0;
        repeat (13) @(posedge clk);
        #1;
        check_eq("prerst_valid", cw_valid, 1);
        reset_n = 1'b0;
        #1;
        check_eq("midrst_valid", cw_valid, 0);
        check_eq("midrst_enc_rst_n", enc_rst_n, 0);
        check_eq("midrst_busy", slice_busy, 0);
        check_eq("midrst_rd_en", coef_rd_en, 0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) coef_mem[i] = 20'(i * 5 - 3);
        run_slice("post_rst_n5", 5, 2, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
